// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//
// Bridges the cache's single-transfer line interface to a multi-beat burst
// protocol toward physical memory. One full line is buffered. A write
// latches the line and streams it out beat 0 first. A read assembles the
// incoming beats in the same order. The cache gets one resp_o pulse per line.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   line_i     in   s_line   write line from the cache
//   line_o     out  s_line   assembled read line to the cache
//   address_i  in   32       line address from the cache
//   read_i     in   1        line read request
//   write_i    in   1        line write request (wins over read_i)
//   resp_o     out  1        one-cycle line completion pulse
//   burst_i    in   s_burst  read beat from memory
//   burst_o    out  s_burst  write beat to memory
//   address_o  out  32       line-aligned burst address
//   read_o     out  1        burst read request
//   write_o    out  1        burst write request
//   resp_i     in   1        memory beat handshake
module cacheline_adaptor #(
  parameter int s_line   = 256,
  parameter int s_burst  = 64,
  parameter int s_offset = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int n_beats = s_line / s_burst;
  localparam int IDX_W   = $clog2(n_beats);
  localparam int CNT_W   = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                          r_state;
  logic [CNT_W-1:0]                r_cnt;
  // Line buffer viewed as beats so the counter indexes it directly.
  logic [n_beats-1:0][s_burst-1:0] r_line;

  logic [IDX_W-1:0]                w_idx;
  logic                            w_last;

  assign w_idx  = r_cnt[IDX_W-1:0];
  assign w_last = (r_cnt == CNT_W'(n_beats - 1));

  assign line_o = r_line;
  // Current write beat, held until memory accepts it; zero outside WRITE.
  assign burst_o = write_o ? r_line[w_idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_line    <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          resp_o <= 1'b0;
          if (write_i) begin
            r_line    <= line_i;
            address_o <= {address_i[31:s_offset], {s_offset{1'b0}}};
            r_cnt     <= '0;
            write_o   <= 1'b1;
            r_state   <= WRITE;
          end else if (read_i) begin
            address_o <= {address_i[31:s_offset], {s_offset{1'b0}}};
            r_cnt     <= '0;
            read_o    <= 1'b1;
            r_state   <= READ;
          end
        end
        READ: begin
          if (resp_i) begin
            r_line[w_idx] <= burst_i;
            r_cnt         <= r_cnt + 1'b1;
            if (w_last) begin
              read_o  <= 1'b0;
              resp_o  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          // Requests are ignored here; the cache drops them on this edge.
          resp_o  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst_n;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int tests = 0;
  int fails = 0;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transfer-level model: phase 0 idle, 1 reading, 2 writing, 3 line complete.
  int          m_ph = 0;
  int          m_n  = 0;
  bit          m_rd = 1'b0;
  logic [31:0] m_addr;
  logic [63:0] m_wb [4];
  logic [63:0] m_rb [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0;
      m_n  = 0;
    end else begin
      case (m_ph)
        0: begin
          if (write_i || read_i) begin
            m_addr = {address_i[31:5], 5'b0};
            m_n    = 0;
            m_rd   = !write_i;
            m_ph   = write_i ? 2 : 1;
            for (int i = 0; i < 4; i++) m_wb[i] = line_i[64*i +: 64];
          end
        end
        1, 2: begin
          if (resp_i) begin
            if (m_ph == 1) m_rb[m_n] = burst_i;
            m_n++;
            if (m_n == 4) m_ph = 3;
          end
        end
        default: m_ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_outputs", {read_o, write_o, resp_o, address_o, burst_o}, '0);
      check("rst_line_o", line_o, '0);
    end else begin
      check("read_o", read_o, m_ph == 1);
      check("write_o", write_o, m_ph == 2);
      check("resp_o", resp_o, m_ph == 3);
      if (m_ph != 0) check("address_o", address_o, m_addr);
      if (m_ph == 2) check("burst_o", burst_o, m_wb[m_n]);
      if (m_ph == 3 && m_rd) check("line_o", line_o, {m_rb[3], m_rb[2], m_rb[1], m_rb[0]});
    end
  end

  // kind: 0 read, 1 write, 2 both requests raised. Starts the request at once,
  // so back-to-back calls raise the next request in the idle cycle after DONE.
  task automatic run_xfer(input string nm, input int kind, input logic [31:0] addr,
                          input logic [31:0] exp_addr, input logic [255:0] data,
                          input int stall_at, input int nstall, input int exp_lat);
    int k, st, cyc;
    bit got;
    k = 0; st = 0; cyc = 0; got = 1'b0;
    address_i = addr;
    line_i    = data;
    read_i    = (kind != 1);
    write_i   = (kind != 0);
    @(posedge clk);
    #1;
    address_i = ~addr;
    line_i    = ~data;
    while (!got && cyc < 40) begin
      if (k < 4 && !(k == stall_at && st < nstall)) begin
        resp_i  = 1'b1;
        burst_i = (kind == 0) ? data[64*k +: 64] : 64'hBAD0_BAD0_BAD0_BAD0;
        if (kind != 0) check({nm, "_beat"}, burst_o, data[64*k +: 64]);
        k++;
      end else begin
        resp_i  = 1'b0;
        burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
        if (k < 4) st++;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (resp_o) begin
        got = 1'b1;
        check({nm, "_latency"}, 256'(cyc + 1), 256'(exp_lat));
        check({nm, "_addr"}, address_o, exp_addr);
        if (kind == 0) check({nm, "_line"}, line_o, data);
      end
    end
    if (!got) check({nm, "_timeout"}, 256'd0, 256'd1);
    resp_i = 1'b0;
    @(posedge clk);
    #1;
    check({nm, "_resp_once"}, resp_o, 1'b0);
    read_i  = 1'b0;
    write_i = 1'b0;
  endtask

  localparam logic [255:0] RLINE = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] WLINE = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                                    64'h9999_0000_AAAA_BBBB, 64'h0123_4567_89AB_CDEF};
  localparam logic [255:0] FLINE = {64'hF0F0_0000_0000_0004, 64'hF0F0_0000_0000_0003,
                                    64'hF0F0_0000_0000_0002, 64'hF0F0_0000_0000_0001};

  initial begin
    rst_n = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = '0; line_i = '0; burst_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {read_o, write_o, resp_o, address_o, burst_o, line_o}, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_xfer("rd_nostall", 0, 32'h0000_1234, 32'h0000_1220, RLINE, -1, 0, 5);
    run_xfer("rd_stall",   0, 32'h0000_1234, 32'h0000_1220, RLINE,  2, 2, 7);
    run_xfer("wr_b2b",     1, 32'h8000_0040, 32'h8000_0040, WLINE, -1, 0, 5);
    run_xfer("wr_stall",   1, 32'h1234_567F, 32'h1234_5660, ~WLINE, 1, 3, 8);

    // Handshakes with no transfer in flight must be ignored.
    repeat (2) @(posedge clk);
    #1;
    resp_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("spurious_idle", {read_o, write_o, resp_o}, 3'b000);
    resp_i = 1'b0;
    @(posedge clk);
    #1;

    run_xfer("both_req", 2, 32'h0000_FFFF, 32'h0000_FFE0, WLINE, -1, 0, 5);

    // Abort a read after three beats.
    @(posedge clk);
    #1;
    address_i = 32'h0000_2000;
    read_i    = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      resp_i  = 1'b1;
      burst_i = 64'hAAAA_0000_0000_0000 + 64'(i);
      @(posedge clk);
      #1;
    end
    resp_i = 1'b0;
    read_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_async", {read_o, resp_o, line_o}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_xfer("rd_after_rst", 0, 32'h0000_2000, 32'h0000_2000, FLINE, -1, 0, 5);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Converts the cache's single-transfer 256-bit line interface into a four-beat, 64-bit burst protocol toward physical memory. Sits directly downstream of the cache. It consumes `pmem_read`, `pmem_write`, `pmem_address` and `pmem_wdata`, and returns `pmem_rdata` and `pmem_resp`. It buffers one full line, sequences the beats and presents a single completion pulse to the cache.

## Interface
- `s_line`, 256: line width in bits.
- `s_burst`, 64: beat width in bits. `s_line` must be an integer multiple of it; beat count `n_beats = s_line/s_burst` (4).
- `s_offset`, 5: line offset bits, which are zeroed on the outgoing address.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `line_i`  in  256  write line from the cache (`pmem_wdata`).
- `line_o`  out  256  read line to the cache (`pmem_rdata`).
- `address_i`  in  32  line address from the cache (`pmem_address`).
- `read_i`  in  1  line read request (`pmem_read`).
- `write_i`  in  1  line write request (`pmem_write`).
- `resp_o`  out  1  line transfer complete (`pmem_resp`).
- `burst_i`  in  64  read beat from memory.
- `burst_o`  out  64  write beat to memory.
- `address_o`  out  32  burst address to memory.
- `read_o`  out  1  burst read request.
- `write_o`  out  1  burst write request.
- `resp_i`  in  1  memory beat handshake.

## Operation
- States: IDLE, READ, WRITE, DONE.
- **Reset:** all outputs are 0, `line_o` = 0, beat counter = 0, state = IDLE.
- **IDLE:**
  - With `write_i` = 1 on a clock edge:
    - latch `line_i` into the line buffer;
    - latch `{address_i[31:5], 5'b0}` into `address_o`;
    - clear the beat counter;
    - go to WRITE.
  - Otherwise, with `read_i` = 1: latch the address the same way, clear the counter, go to READ.
  - If both requests are high, write wins. The cache never does this; the rule is defined only for robustness.
  - `resp_i` is ignored in IDLE.
- **READ:**
  - `read_o` = 1.
  - On each edge with `resp_i` = 1, write `burst_i` into line buffer beat k = counter, bits [64k+63:64k], then increment the counter.
  - On the edge accepting beat `n_beats-1`, go to DONE.
  - Cycles with `resp_i` = 0 are stalls; the counter holds.
- **WRITE:**
  - `write_o` = 1, `burst_o` = buffer beat k = counter. The beat is combinational from the counter and stable until accepted.
  - On each edge with `resp_i` = 1, increment the counter.
  - After beat `n_beats-1` is accepted, go to DONE.
- **DONE:**
  - `resp_o` = 1 for exactly one cycle; `read_o` = `write_o` = 0; `line_o` = the full assembled line.
  - Unconditionally return to IDLE.
- **Outputs outside DONE:** `line_o` holds its last assembled value. Only DONE guarantees validity.
- **Upstream requirement:** the cache drops `read_i`/`write_i` on the edge where it samples `resp_o`. A request still high in the IDLE cycle after DONE starts a new transfer.
- **Address and inputs:** `address_o` is stable from request acceptance through DONE. `address_i` and `line_i` changes after acceptance are ignored.
- **Counter width:** log2(`n_beats`) + 1 bits. It never wraps within a transfer.

## Timing
- **Acceptance:** request sampled at edge E0. `read_o`/`write_o` are high from E0 through the edge accepting the last beat.
- **Minimum read latency:**
  - `resp_i` high on the 4 cycles after E0 gives beats at E1..E4, DONE after E4, `resp_o` high in the cycle following E4.
  - Total is 5 cycles from request sample to `resp_o`.
- **Stalls:** each `resp_i`-low cycle during a burst adds exactly one cycle.
- **Write latency:** identical to read.
- **Reset mid-burst:** outputs clear immediately, with no clock needed. No `resp_o` is produced for the aborted transfer. After `rst_n` rises, the first edge with a request starts a fresh burst at beat 0.

## Test plan
- **Read, no stalls:** `read_i`, `address_i` = 0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 consecutively → `address_o` = 0x0000_1220, `resp_o` one cycle 5 cycles after the request, `line_o` = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- **Read with stalls:** same beats, `resp_i` low 2 cycles between beats 1 and 2 → `resp_o` at cycle 7, same `line_o`, and the counter does not advance during the stall.
- **Write:** `line_i` = 0x0123…CDEF (256-bit pattern), `address_i` = 0x8000_0040 → `write_o` high with `burst_o` = line[63:0], [127:64], [191:128], [255:192] in order, advancing only on `resp_i`; `resp_o` pulse once.
- **Back-to-back:** a read completes, the cache raises `write_i` in the cycle after DONE → a new write burst starts with counter 0 and no stale beat data.
- **Reset mid-read:** assert `rst_n` = 0 after beat 2 → `read_o`, `resp_o` = 0 immediately, `line_o` = 0. Release and issue a new read → 4 fresh beats are required before `resp_o`.
- **Spurious/simultaneous:** `resp_i` pulses in IDLE → no state change. `read_i` and `write_i` both high → a write burst is performed.
